// File: rtl/sig_seq_pkg.sv
// Shared types and constants for the signature sequence monitor.
// Optional timestamp capture is enabled by defining SIG_SEQ_TSTAMP_EN.
package sig_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_PASS  = 2'd2,
    ST_FAIL  = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_TMO     = 2'd1;
  localparam logic [1:0] CAUSE_RESTART = 2'd2;

  localparam int TSTAMP_W = 32;

endpackage

// File: rtl/sig_stab_filter.sv
// Masked signature compare plus the consecutive-match stability counter;
// o_adv fires on the sample that completes STABLE_CYC matching samples.
module sig_stab_filter
  import sig_seq_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int STABLE_CYC = 2
) (
  input  logic             mclk,
  input  logic             reset_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_sig,
  input  logic [WIDTH-1:0] i_code,
  input  logic [WIDTH-1:0] i_mask,
  output logic             o_adv
);

  localparam int CNT_W = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYC - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_hit;

  assign w_hit = i_en && (((i_sig ^ i_code) & i_mask) == {WIDTH{1'b0}});
  assign o_adv = w_hit && (r_cnt == LAST_CNT);

  // Count consecutive hits; any miss or a completed stage restarts the count.
  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr || !w_hit || o_adv) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sig_seq_monitor.sv
// Watches a signature bus for an ordered list of codes with a per-stage timeout.
// Define SIG_SEQ_TSTAMP_EN to add per-stage advance timestamps (stage_tstamp).
module sig_seq_monitor
  import sig_seq_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int NUM_STAGE  = 4,
  parameter int TMO_W      = 24,
  parameter int STABLE_CYC = 2
) (
  input  logic                               mclk,
  input  logic                               reset_n,
  input  logic                               start,
  input  logic                               clear,
  input  logic [WIDTH-1:0]                   sig_in,
  input  logic [WIDTH-1:0]                   sig_mask,
  input  logic [NUM_STAGE*WIDTH-1:0]         exp_codes,
  input  logic [TMO_W-1:0]                   tmo_limit,
  output logic                               busy,
  output logic                               pass,
  output logic                               fail,
  output logic [1:0]                         fail_cause,
  output logic [$clog2(NUM_STAGE+1)-1:0]     stage_idx
`ifdef SIG_SEQ_TSTAMP_EN
  ,output logic [NUM_STAGE*TSTAMP_W-1:0]     stage_tstamp
`endif
);

  localparam int IDX_W = $clog2(NUM_STAGE + 1);

  state_t           r_state, w_state_nx;
  logic [WIDTH-1:0] r_sig_q;
  logic [IDX_W-1:0] r_stage_idx, w_stage_nx, w_sel;
  logic [1:0]       r_cause, w_cause_nx;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_busy, r_pass, r_fail;
  logic [WIDTH-1:0] w_code;
  logic             w_armed, w_adv, w_adv_taken, w_expire, w_arm_evt;

  assign w_armed     = (r_state == ST_ARMED);
  assign w_sel       = (r_stage_idx < IDX_W'(NUM_STAGE)) ? r_stage_idx : '0;
  assign w_code      = exp_codes[int'(w_sel)*WIDTH +: WIDTH];
  assign w_adv_taken = w_adv && !start && !clear;
  assign w_expire    = w_armed && (tmo_limit != '0) && (r_tmo_cnt == tmo_limit - TMO_W'(1));
  assign w_arm_evt   = (w_state_nx == ST_ARMED) && !w_armed;

  sig_stab_filter #(
    .WIDTH      (WIDTH),
    .STABLE_CYC (STABLE_CYC)
  ) u_filter (
    .mclk    (mclk),
    .reset_n (reset_n),
    .i_en    (w_armed),
    .i_clr   (start | clear),
    .i_sig   (r_sig_q),
    .i_code  (w_code),
    .i_mask  (sig_mask),
    .o_adv   (w_adv)
  );

  // Next-state logic: clear beats start, start beats advance, advance beats timeout.
  always_comb begin
    w_state_nx = r_state;
    w_stage_nx = r_stage_idx;
    w_cause_nx = r_cause;
    if (clear) begin
      w_state_nx = ST_IDLE;
      w_stage_nx = '0;
      w_cause_nx = CAUSE_NONE;
    end else if (start) begin
      w_stage_nx = '0;
      if (w_armed) begin
        w_state_nx = ST_FAIL;
        w_cause_nx = CAUSE_RESTART;
      end else begin
        w_state_nx = ST_ARMED;
        w_cause_nx = CAUSE_NONE;
      end
    end else begin
      case (r_state)
        ST_ARMED: begin
          if (w_adv) begin
            w_stage_nx = r_stage_idx + IDX_W'(1);
            if (r_stage_idx == IDX_W'(NUM_STAGE - 1)) begin
              w_state_nx = ST_PASS;
            end else begin
              w_state_nx = ST_ARMED;
            end
          end else if (w_expire) begin
            w_state_nx = ST_FAIL;
            w_cause_nx = CAUSE_TMO;
          end else begin
            w_state_nx = ST_ARMED;
          end
        end
        // A restart-induced FAIL lasts one cycle, then the monitor re-arms itself.
        ST_FAIL: begin
          if (r_cause == CAUSE_RESTART) begin
            w_state_nx = ST_ARMED;
            w_stage_nx = '0;
            w_cause_nx = CAUSE_NONE;
          end else begin
            w_state_nx = ST_FAIL;
          end
        end
        default: begin
          w_state_nx = r_state;
        end
      endcase
    end
  end

  // Signature sample register; every compare works on this copy.
  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      r_sig_q <= '0;
    end else begin
      r_sig_q <= sig_in;
    end
  end

  // State, stage index and status flags, all taken from the next-state view.
  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_stage_idx <= '0;
      r_cause     <= CAUSE_NONE;
      r_busy      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_stage_idx <= w_stage_nx;
      r_cause     <= w_cause_nx;
      r_busy      <= (w_state_nx == ST_ARMED);
      r_pass      <= (w_state_nx == ST_PASS);
      r_fail      <= (w_state_nx == ST_FAIL);
    end
  end

  // Per-stage timeout counter, restarted on arm and on every accepted advance.
  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      r_tmo_cnt <= '0;
    end else if ((w_state_nx != ST_ARMED) || w_arm_evt || w_adv_taken) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end
  end

  assign busy       = r_busy;
  assign pass       = r_pass;
  assign fail       = r_fail;
  assign fail_cause = r_cause;
  assign stage_idx  = r_stage_idx;

`ifdef SIG_SEQ_TSTAMP_EN
  logic [TSTAMP_W-1:0]           r_ts_cnt;
  logic [NUM_STAGE*TSTAMP_W-1:0] r_ts;

  // Cycle counter that reads k on the k-th edge after arming.
  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      r_ts_cnt <= '0;
    end else if (w_arm_evt) begin
      r_ts_cnt <= '0;
    end else begin
      r_ts_cnt <= r_ts_cnt + TSTAMP_W'(1);
    end
  end

  // Capture the edge number of each advance into its stage slot.
  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      r_ts <= '0;
    end else if (start) begin
      r_ts <= '0;
    end else if (w_adv_taken) begin
      for (int k = 0; k < NUM_STAGE; k++) begin
        if (r_stage_idx == IDX_W'(k)) begin
          r_ts[k*TSTAMP_W +: TSTAMP_W] <= r_ts_cnt + TSTAMP_W'(1);
        end
      end
    end
  end

  assign stage_tstamp = r_ts;
`endif

endmodule

// File: tb/tb_sig_seq_monitor.sv
// Directed self-checking bench for sig_seq_monitor (default parameters).
// Timestamp checks are included when SIG_SEQ_TSTAMP_EN is defined.
module tb_sig_seq_monitor;
  import sig_seq_pkg::*;

  logic        mclk;
  logic        reset_n;
  logic        start;
  logic        clear;
  logic [15:0] sig_in;
  logic [15:0] sig_mask;
  logic [63:0] exp_codes;
  logic [23:0] tmo_limit;
  logic        busy;
  logic        pass;
  logic        fail;
  logic [1:0]  fail_cause;
  logic [2:0]  stage_idx;
  logic [7:0]  status;
`ifdef SIG_SEQ_TSTAMP_EN
  logic [127:0] stage_tstamp;
`endif

  int errors;
  int checks;

  localparam logic [63:0] EXP_DEF = {16'hAB6A, 16'hAB62, 16'hAB61, 16'hAB60};

  sig_seq_monitor dut (
    .mclk       (mclk),
    .reset_n    (reset_n),
    .start      (start),
    .clear      (clear),
    .sig_in     (sig_in),
    .sig_mask   (sig_mask),
    .exp_codes  (exp_codes),
    .tmo_limit  (tmo_limit),
    .busy       (busy),
    .pass       (pass),
    .fail       (fail),
    .fail_cause (fail_cause),
    .stage_idx  (stage_idx)
`ifdef SIG_SEQ_TSTAMP_EN
    ,.stage_tstamp (stage_tstamp)
`endif
  );

  // status = {busy, pass, fail, fail_cause[1:0], stage_idx[2:0]}
  assign status = {busy, pass, fail, fail_cause, stage_idx};

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge mclk);
      #1;
    end
  endtask

  task automatic arm();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; clear = 1'b0;
    sig_in = 16'h0000; sig_mask = 16'hFFFF; exp_codes = EXP_DEF; tmo_limit = 24'd1000;
    step(2);
    checks++;
    if (status !== 8'h00) begin
      errors++; $display("FAIL reset_state: got %b expected %b", status, 8'h00);
    end
    reset_n = 1'b1;
    step(1);
    checks++;
    if (status !== 8'h00) begin
      errors++; $display("FAIL idle_after_reset: got %b expected %b", status, 8'h00);
    end
  endtask

  task automatic test_sequence();
    logic [15:0] codes [4];
    codes[0] = 16'hAB60; codes[1] = 16'hAB61; codes[2] = 16'hAB62; codes[3] = 16'hAB6A;
    arm();
    checks++;
    if (status !== {1'b1, 1'b0, 1'b0, 2'd0, 3'd0}) begin
      errors++; $display("FAIL arm: got %b expected %b", status, {1'b1, 1'b0, 1'b0, 2'd0, 3'd0});
    end
    // A code first driven before edge 1 advances on edge 3 (STABLE_CYC=2).
    sig_in = codes[0];
    step(2);
    checks++;
    if (stage_idx !== 3'd0) begin
      errors++; $display("FAIL adv_not_early: got %0d expected 0", stage_idx);
    end
    step(1);
    checks++;
    if (stage_idx !== 3'd1) begin
      errors++; $display("FAIL adv_latency: got %0d expected 1", stage_idx);
    end
    step(2);
    for (int k = 1; k < 4; k++) begin
      sig_in = codes[k];
      step(5);
      checks++;
      if (status !== {(k < 3), (k == 3), 1'b0, 2'd0, 3'(k + 1)}) begin
        errors++; $display("FAIL seq_stage%0d: got %b expected %b", k, status, {(k < 3), (k == 3), 1'b0, 2'd0, 3'(k + 1)});
      end
    end
    step(4);
    checks++;
    if (status !== {1'b0, 1'b1, 1'b0, 2'd0, 3'd4}) begin
      errors++; $display("FAIL pass_hold: got %b expected %b", status, {1'b0, 1'b1, 1'b0, 2'd0, 3'd4});
    end
  endtask

  task automatic test_back_to_back();
    sig_in = 16'h0000;
    arm();
    checks++;
    if (status !== {1'b1, 1'b0, 1'b0, 2'd0, 3'd0}) begin
      errors++; $display("FAIL rearm_from_pass: got %b expected %b", status, {1'b1, 1'b0, 1'b0, 2'd0, 3'd0});
    end
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    checks++;
    if (status !== 8'h00) begin
      errors++; $display("FAIL clear_to_idle: got %b expected %b", status, 8'h00);
    end
  endtask

  task automatic test_timeout();
    // Stage 1 expects AB63 here, so the held AB61 never matches.
    exp_codes = {16'hAB6A, 16'hAB62, 16'hAB63, 16'hAB60};
    tmo_limit = 24'd100;
    sig_in = 16'h0000;
    arm();
    sig_in = 16'hAB60;
    step(3);
    checks++;
    if (stage_idx !== 3'd1) begin
      errors++; $display("FAIL tmo_stage1: got %0d expected 1", stage_idx);
    end
    sig_in = 16'hAB61;
    step(99);
    checks++;
    if (status !== {1'b1, 1'b0, 1'b0, 2'd0, 3'd1}) begin
      errors++; $display("FAIL tmo_not_early: got %b expected %b", status, {1'b1, 1'b0, 1'b0, 2'd0, 3'd1});
    end
    step(1);
    checks++;
    if (status !== {1'b0, 1'b0, 1'b1, 2'd1, 3'd1}) begin
      errors++; $display("FAIL tmo_fail: got %b expected %b", status, {1'b0, 1'b0, 1'b1, 2'd1, 3'd1});
    end
    step(5);
    checks++;
    if (status !== {1'b0, 1'b0, 1'b1, 2'd1, 3'd1}) begin
      errors++; $display("FAIL tmo_hold: got %b expected %b", status, {1'b0, 1'b0, 1'b1, 2'd1, 3'd1});
    end
  endtask

  task automatic test_glitch();
    exp_codes = EXP_DEF;
    tmo_limit = 24'd0;
    sig_in = 16'h0000;
    arm();
    checks++;
    if (status !== {1'b1, 1'b0, 1'b0, 2'd0, 3'd0}) begin
      errors++; $display("FAIL rearm_from_fail: got %b expected %b", status, {1'b1, 1'b0, 1'b0, 2'd0, 3'd0});
    end
    sig_in = 16'hAB60;
    step(1);
    sig_in = 16'h0000;
    step(4);
    checks++;
    if (stage_idx !== 3'd0) begin
      errors++; $display("FAIL glitch_ignored: got %0d expected 0", stage_idx);
    end
    sig_in = 16'hAB60;
    step(2);
    sig_in = 16'h0000;
    checks++;
    if (stage_idx !== 3'd0) begin
      errors++; $display("FAIL stable_pending: got %0d expected 0", stage_idx);
    end
    step(1);
    checks++;
    if (stage_idx !== 3'd1) begin
      errors++; $display("FAIL stable_two: got %0d expected 1", stage_idx);
    end
  endtask

  task automatic test_mask();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    sig_mask  = 16'hFF00;
    exp_codes = {16'h0000, 16'h0000, 16'hCD00, 16'hAB00};
    sig_in    = 16'hAC00;
    arm();
    step(5);
    checks++;
    if (stage_idx !== 3'd0) begin
      errors++; $display("FAIL mask_nomatch: got %0d expected 0", stage_idx);
    end
    sig_in = 16'hAB5F;
    step(3);
    checks++;
    if (stage_idx !== 3'd1) begin
      errors++; $display("FAIL mask_match: got %0d expected 1", stage_idx);
    end
    step(3);
    checks++;
    if (status !== {1'b1, 1'b0, 1'b0, 2'd0, 3'd1}) begin
      errors++; $display("FAIL mask_hold: got %b expected %b", status, {1'b1, 1'b0, 1'b0, 2'd0, 3'd1});
    end
  endtask

  task automatic test_restart();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    sig_mask = 16'hFFFF; exp_codes = EXP_DEF; tmo_limit = 24'd0; sig_in = 16'h0000;
    arm();
    sig_in = 16'hAB60;
    step(3);
    sig_in = 16'hAB61;
    step(3);
    checks++;
    if (stage_idx !== 3'd2) begin
      errors++; $display("FAIL restart_stage2: got %0d expected 2", stage_idx);
    end
    arm();
    checks++;
    if (status[7:3] !== 5'b00110) begin
      errors++; $display("FAIL restart_fail: got %b expected 00110", status[7:3]);
    end
    step(1);
    checks++;
    if (status !== {1'b1, 1'b0, 1'b0, 2'd0, 3'd0}) begin
      errors++; $display("FAIL restart_rearm: got %b expected %b", status, {1'b1, 1'b0, 1'b0, 2'd0, 3'd0});
    end
    sig_in = 16'hAB60;
    step(3);
    reset_n = 1'b0;
    step(1);
    checks++;
    if (status !== 8'h00) begin
      errors++; $display("FAIL reset_in_armed: got %b expected %b", status, 8'h00);
    end
    reset_n = 1'b1;
    start = 1'b1; clear = 1'b1;
    step(1);
    start = 1'b0; clear = 1'b0;
    checks++;
    if (status !== 8'h00) begin
      errors++; $display("FAIL clear_over_start: got %b expected %b", status, 8'h00);
    end
  endtask

`ifdef SIG_SEQ_TSTAMP_EN
  task automatic test_tstamp();
    logic [15:0] codes [4];
    codes[0] = 16'hAB60; codes[1] = 16'hAB61; codes[2] = 16'hAB62; codes[3] = 16'hAB6A;
    sig_in = 16'h0000; sig_mask = 16'hFFFF; exp_codes = EXP_DEF; tmo_limit = 24'd0;
    arm();
    for (int k = 0; k < 4; k++) begin
      step(7);
      sig_in = codes[k];
      step(3);
    end
    checks++;
    if (stage_tstamp !== {32'd40, 32'd30, 32'd20, 32'd10}) begin
      errors++; $display("FAIL tstamp: got %h expected %h", stage_tstamp, {32'd40, 32'd30, 32'd20, 32'd10});
    end
    arm();
    checks++;
    if (stage_tstamp !== 128'd0) begin
      errors++; $display("FAIL tstamp_clear: got %h expected 0", stage_tstamp);
    end
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_sequence();
    test_back_to_back();
    test_timeout();
    test_glitch();
    test_mask();
    test_restart();
`ifdef SIG_SEQ_TSTAMP_EN
    test_tstamp();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sig_seq_monitor.md
SIG_SEQ_MONITOR -- requirements
Module: sig_seq_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning monitored signature bus width.
REQ-002 SHALL have parameter NUM_STAGE, default 4, meaning number of expected codes in the sequence (1..16).
REQ-003 SHALL have parameter TMO_W, default 24, meaning timeout counter width.
REQ-004 SHALL have parameter STABLE_CYC, default 2, meaning consecutive matching samples required per stage (>=1).
REQ-005 SHALL have port mclk, input, 1, the single clock.
REQ-006 SHALL have port reset_n, input, 1, reset; synchronous, active-low, sampled on rising mclk.
REQ-007 SHALL have port start, input, 1, a one-cycle pulse that arms the monitor.
REQ-008 SHALL have port clear, input, 1, a one-cycle pulse that returns the monitor to IDLE.
REQ-009 SHALL have port sig_in, input, WIDTH, the monitored signature bus (e.g. mprj_io[31:16]).
REQ-010 SHALL have port sig_mask, input, WIDTH, the compare mask (1 = bit compared).
REQ-011 SHALL have port exp_codes, input, NUM_STAGE*WIDTH, the expected code for stage k, located at bits [k*WIDTH +: WIDTH].
REQ-012 SHALL have port tmo_limit, input, TMO_W, the per-stage cycle budget (0 = timeout disabled).
REQ-013 SHALL have outputs busy (1), pass (1), fail (1), fail_cause (2: 0 none, 1 timeout, 2 restart) and stage_idx ($clog2(NUM_STAGE+1), number of stages matched).

Function
REQ-014 SHALL register sig_in into sig_q every cycle; all compares SHALL use sig_q.
REQ-015 SHALL define hit = ((sig_q ^ exp_codes[stage_idx]) & sig_mask) == 0, evaluated only in ARMED.
REQ-016 SHALL keep a stability counter that increments on hit, clears on a miss and clears on every stage advance.
REQ-017 SHALL advance stage_idx in the cycle where hit && stab_cnt == STABLE_CYC-1; a code held from the sig_in edge SHALL therefore advance STABLE_CYC+1 edges later.
REQ-018 SHALL implement the FSM: IDLE -start-> ARMED; ARMED -last stage advance-> PASS; ARMED -timeout-> FAIL; PASS/FAIL -start-> ARMED; any state -clear-> IDLE.
REQ-019 SHALL have busy=1 only in ARMED, pass=1 only in PASS and fail=1 only in FAIL; outputs SHALL be registered.
REQ-020 SHALL run a timeout counter in ARMED, cleared on arm and on each stage advance; when tmo_limit!=0 and count==tmo_limit-1 without an advance, the FSM SHALL go to FAIL with fail_cause=1.
REQ-021 On start while ARMED, SHALL latch FAIL with fail_cause=2 for one cycle and then re-arm (stage_idx=0).
REQ-022 Precedence SHALL be clear > start > stage advance > timeout; an advance and an expiry in the same cycle SHALL count as an advance.
REQ-023 Out-of-order codes SHALL be ignored; only exp_codes[stage_idx] is matched.
REQ-024 stage_idx SHALL saturate at NUM_STAGE and SHALL hold in PASS/FAIL until start or clear.

Reset
REQ-025 reset_n=0 at a clock edge SHALL force IDLE, with busy/pass/fail=0, fail_cause=0, stage_idx=0, all counters 0 and sig_q=0, including during ARMED.

Configuration
REQ-026 With SIG_SEQ_TSTAMP_EN defined, SHALL add output stage_tstamp (NUM_STAGE*32), holding a free-running 32-bit cycle count (counting from arm) captured at each stage advance; entries SHALL clear on start/reset. Without the macro, the port and counter SHALL be absent.

Structure
REQ-027 SHALL place the FSM state enum, the fail_cause encodings and the TSTAMP width constant in package sig_seq_pkg.
REQ-028 SHALL implement the masked compare and stability counter in one sub-module, sig_stab_filter.

Verification
REQ-029 WIDTH=16, exp={AB60,AB61,AB62,AB6A}, mask=FFFF, tmo=1000; drive the codes in order, each held 5 cycles -> pass=1, stage_idx=4, fail=0.
REQ-030 Drive AB60 then hold AB61 with tmo_limit=100 -> fail=1, fail_cause=1, stage_idx=1, and the FAIL transition occurs exactly 100 cycles after the stage-1 advance.
REQ-031 STABLE_CYC=2; glitch AB60 for 1 cycle, then 0000 -> stage_idx stays 0; hold AB60 for 2 cycles -> stage_idx=1.
REQ-032 mask=FF00, exp0=AB00; drive AB5F -> stage 0 matches; drive AC00 -> no match.
REQ-033 Assert start mid-sequence at stage 2 -> one-cycle fail with fail_cause=2, then busy=1 and stage_idx=0; assert reset_n=0 in ARMED -> all outputs 0 on the next edge.
REQ-034 With SIG_SEQ_TSTAMP_EN, advances at cycles 10/20/30/40 after arm -> stage_tstamp entries equal 10/20/30/40.
